// File: rtl/cache_pkg.sv
// Shared constants and helpers for the tree pseudo-LRU state.
// Trees are carried at max width (15 bits) and walked up to 4 levels.
package cache_pkg;

  localparam int PLRU_MAX_ASSOC = 16;
  localparam int PLRU_TREE_W = PLRU_MAX_ASSOC - 1;

  typedef logic [PLRU_TREE_W-1:0] plru_tree_t;
  typedef logic [3:0] plru_way_t;

  // Follow the node bits from the root down to a leaf.
  function automatic plru_way_t plru_victim(
    input plru_tree_t tree,
    input int levels
  );
    int node;
    node = 0;
    for (int l = 0; l < 4; l++) begin
      if (l < levels) begin
        node = 2 * node + 1 + int'(tree[node]);
      end
    end
    return plru_way_t'(node - ((1 << levels) - 1));
  endfunction

  // Climb from the leaf; a left child (odd heap index)
  // makes its parent point right, and vice versa.
  function automatic plru_tree_t plru_update(
    input plru_tree_t tree,
    input plru_way_t way,
    input int levels
  );
    plru_tree_t t;
    int node;
    int parent;
    t = tree;
    node = int'(way) + (1 << levels) - 1;
    for (int l = 0; l < 4; l++) begin
      if (node != 0) begin
        parent = (node - 1) >> 1;
        t[parent] = node[0];
        node = parent;
      end
    end
    return t;
  endfunction

  function automatic plru_way_t lowest_zero(
    input logic [PLRU_MAX_ASSOC-1:0] mask
  );
    plru_way_t r;
    r = '0;
    for (int i = PLRU_MAX_ASSOC - 1; i >= 0; i--) begin
      if (!mask[i]) r = plru_way_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_plru_array_if.sv
// Query/update/victim bundle for the PLRU state array.
// master drives query and update, slave returns the victim.
interface cache_plru_array_if #(
  parameter int ASSOC_NUM = 4,
  parameter int SET_NUM = 64
);
  localparam int WAY_W = $clog2(ASSOC_NUM);
  localparam int IDX_W = $clog2(SET_NUM);

  logic query_valid;
  logic [IDX_W-1:0] query_index;
  logic [ASSOC_NUM-1:0] valid_mask;
  logic upd_en;
  logic [IDX_W-1:0] upd_index;
  logic [ASSOC_NUM-1:0] upd_access;
  logic victim_valid;
  logic [WAY_W-1:0] victim_way;
  logic [ASSOC_NUM-1:0] victim_onehot;

  modport master (
    output query_valid, query_index, valid_mask,
    output upd_en, upd_index, upd_access,
    input victim_valid, victim_way, victim_onehot
  );

  modport slave (
    input query_valid, query_index, valid_mask,
    input upd_en, upd_index, upd_access,
    output victim_valid, victim_way, victim_onehot
  );

endinterface

// File: rtl/plru_tree_node_logic.sv
// Combinational next-state and victim for one PLRU tree.
// tree/access in; next_tree and victim of next_tree out.
module plru_tree_node_logic
  import cache_pkg::*;
#(
  parameter int ASSOC_NUM = 4,
  localparam int WAY_W = $clog2(ASSOC_NUM)
) (
  input  logic [ASSOC_NUM-2:0] tree,
  input  logic [ASSOC_NUM-1:0] access,
  output logic [WAY_W-1:0] victim,
  output logic [ASSOC_NUM-2:0] next_tree
);

  plru_tree_t t;
  plru_tree_t nt;
  plru_way_t way;

  always_comb begin
    t = '0;
    t[ASSOC_NUM-2:0] = tree;
    way = '0;
    // lowest set bit wins on a multi-hot access
    for (int i = ASSOC_NUM - 1; i >= 0; i--) begin
      if (access[i]) way = plru_way_t'(i);
    end
    nt = (|access) ? plru_update(t, way, WAY_W) : t;
    next_tree = nt[ASSOC_NUM-2:0];
    victim = WAY_W'(plru_victim(nt, WAY_W));
  end

endmodule

// File: rtl/cache_plru_array.sv
// Per-set tree PLRU state with registered victim output.
// clk/resetn/clear plain; query, update and victim on bus.
module cache_plru_array
  import cache_pkg::*;
#(
  parameter int ASSOC_NUM = 4,
  parameter int SET_NUM = 64,
  localparam int WAY_W = $clog2(ASSOC_NUM)
) (
  input logic clk,
  input logic resetn,
  input logic clear,
  cache_plru_array_if.slave bus
);

  logic [ASSOC_NUM-2:0] state [SET_NUM];

  logic [ASSOC_NUM-2:0] upd_next;
  logic [WAY_W-1:0] upd_victim;
  logic [ASSOC_NUM-2:0] qry_next_unused;
  logic [WAY_W-1:0] qry_victim;

  logic fwd;
  logic [WAY_W-1:0] tree_victim;
  logic [WAY_W-1:0] victim_next;
  logic [PLRU_MAX_ASSOC-1:0] mask_ext;

  plru_tree_node_logic #(.ASSOC_NUM(ASSOC_NUM)) u_upd (
    .tree      (state[bus.upd_index]),
    .access    (bus.upd_access),
    .victim    (upd_victim),
    .next_tree (upd_next)
  );

  plru_tree_node_logic #(.ASSOC_NUM(ASSOC_NUM)) u_qry (
    .tree      (state[bus.query_index]),
    .access    ('0),
    .victim    (qry_victim),
    .next_tree (qry_next_unused)
  );

  // upd_victim is already the post-update victim of the
  // updated set, so a same-index query just reuses it.
  assign fwd = bus.upd_en &&
               (bus.upd_index == bus.query_index);

  always_comb begin
    tree_victim = fwd ? upd_victim : qry_victim;
    if (clear) tree_victim = '0;
    mask_ext = '1;
    mask_ext[ASSOC_NUM-1:0] = bus.valid_mask;
    victim_next = tree_victim;
    if (!(&bus.valid_mask)) begin
      victim_next = WAY_W'(lowest_zero(mask_ext));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SET_NUM; s++) state[s] <= '0;
    end else if (clear) begin
      for (int s = 0; s < SET_NUM; s++) state[s] <= '0;
    end else if (bus.upd_en && (|bus.upd_access)) begin
      state[bus.upd_index] <= upd_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.victim_valid <= 1'b0;
      bus.victim_way <= '0;
      bus.victim_onehot <= '0;
    end else begin
      bus.victim_valid <= bus.query_valid;
      if (bus.query_valid) begin
        bus.victim_way <= victim_next;
        bus.victim_onehot <= ASSOC_NUM'(1) << victim_next;
      end
    end
  end

endmodule

// File: tb/tb_cache_plru_array.sv
// Directed bench for cache_plru_array (4-way and 8-way, 8 sets).
// Each task drives one scenario and checks its own results.
module tb_cache_plru_array;

  logic clk;
  logic resetn;
  logic clear;

  int n_checks;
  int n_fail;

  cache_plru_array_if #(.ASSOC_NUM(4), .SET_NUM(8)) if4 ();
  cache_plru_array_if #(.ASSOC_NUM(8), .SET_NUM(8)) if8 ();

  cache_plru_array #(.ASSOC_NUM(4), .SET_NUM(8)) dut4 (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .bus    (if4.slave)
  );

  cache_plru_array #(.ASSOC_NUM(8), .SET_NUM(8)) dut8 (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .bus    (if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    clear = 1'b0;
    if4.query_valid = 1'b0;
    if4.query_index = '0;
    if4.valid_mask = '1;
    if4.upd_en = 1'b0;
    if4.upd_index = '0;
    if4.upd_access = '0;
    if8.query_valid = 1'b0;
    if8.query_index = '0;
    if8.valid_mask = '1;
    if8.upd_en = 1'b0;
    if8.upd_index = '0;
    if8.upd_access = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic q4(input logic [2:0] idx, input logic [3:0] m);
    if4.query_valid = 1'b1;
    if4.query_index = idx;
    if4.valid_mask = m;
  endtask

  task automatic u4(input logic [2:0] idx, input logic [3:0] a);
    if4.upd_en = 1'b1;
    if4.upd_index = idx;
    if4.upd_access = a;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    #12;
    n_checks++;
    if (if4.victim_valid !== 1'b0 || if4.victim_way !== 2'd0 ||
        if4.victim_onehot !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_out: v=%b w=%0d oh=%b want 0/0/0",
               if4.victim_valid, if4.victim_way, if4.victim_onehot);
    end
    resetn = 1'b1;
    @(posedge clk);
    #1;
    q4(3'd3, 4'hF);
    step();
    n_checks++;
    if (if4.victim_valid !== 1'b1 || if4.victim_way !== 2'd0 ||
        if4.victim_onehot !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_query: v=%b w=%0d oh=%b want 1/0/0001",
               if4.victim_valid, if4.victim_way, if4.victim_onehot);
    end
    step();
    n_checks++;
    if (if4.victim_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_one_cycle: v=%b want 0", if4.victim_valid);
    end
  endtask

  task automatic test_update_seq();
    u4(3'd5, 4'b0001);
    step();
    q4(3'd5, 4'hF);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd2 || if4.victim_onehot !== 4'b0100) begin
      n_fail++;
      $display("FAIL upd_way0: w=%0d oh=%b want 2/0100",
               if4.victim_way, if4.victim_onehot);
    end
    u4(3'd5, 4'b0100);
    q4(3'd4, 4'hF);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd0) begin
      n_fail++;
      $display("FAIL other_set: w=%0d want 0", if4.victim_way);
    end
    q4(3'd5, 4'hF);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd1) begin
      n_fail++;
      $display("FAIL upd_way2: w=%0d want 1", if4.victim_way);
    end
    u4(3'd5, 4'b1010);
    step();
    q4(3'd5, 4'hF);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd3 || if4.victim_onehot !== 4'b1000) begin
      n_fail++;
      $display("FAIL upd_way1_multihot: w=%0d oh=%b want 3/1000",
               if4.victim_way, if4.victim_onehot);
    end
    u4(3'd5, 4'b0000);
    step();
    q4(3'd5, 4'hF);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd3) begin
      n_fail++;
      $display("FAIL zero_access: w=%0d want 3", if4.victim_way);
    end
  endtask

  task automatic test_forward();
    u4(3'd2, 4'b0001);
    q4(3'd2, 4'hF);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd2) begin
      n_fail++;
      $display("FAIL fwd_same: w=%0d want 2", if4.victim_way);
    end
    u4(3'd6, 4'b0001);
    step();
    u4(3'd2, 4'b0001);
    q4(3'd6, 4'hF);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd2) begin
      n_fail++;
      $display("FAIL fwd_indep_q: w=%0d want 2", if4.victim_way);
    end
    u4(3'd2, 4'b0100);
    q4(3'd7, 4'hF);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd0) begin
      n_fail++;
      $display("FAIL fwd_diff: w=%0d want 0", if4.victim_way);
    end
    q4(3'd2, 4'hF);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd1) begin
      n_fail++;
      $display("FAIL diff_upd_kept: w=%0d want 1", if4.victim_way);
    end
  endtask

  task automatic test_invalid_pref();
    u4(3'd1, 4'b0001);
    step();
    q4(3'd1, 4'b1011);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd2 || if4.victim_onehot !== 4'b0100) begin
      n_fail++;
      $display("FAIL inv_1011: w=%0d oh=%b want 2/0100",
               if4.victim_way, if4.victim_onehot);
    end
    q4(3'd1, 4'b0000);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd0) begin
      n_fail++;
      $display("FAIL inv_0000: w=%0d want 0", if4.victim_way);
    end
    q4(3'd1, 4'b0111);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd3) begin
      n_fail++;
      $display("FAIL inv_0111: w=%0d want 3", if4.victim_way);
    end
  endtask

  task automatic test_assoc8();
    for (int w = 0; w < 8; w++) begin
      if8.upd_en = 1'b1;
      if8.upd_index = 3'd0;
      if8.upd_access = 8'(1) << w;
      step();
    end
    if8.query_valid = 1'b1;
    if8.query_index = 3'd0;
    if8.valid_mask = 8'hFF;
    step();
    n_checks++;
    if (if8.victim_way !== 3'd0 || if8.victim_onehot !== 8'h01) begin
      n_fail++;
      $display("FAIL a8_seq: w=%0d oh=%h want 0/01",
               if8.victim_way, if8.victim_onehot);
    end
    if8.upd_en = 1'b1;
    if8.upd_index = 3'd0;
    if8.upd_access = 8'h01;
    step();
    if8.query_valid = 1'b1;
    if8.query_index = 3'd0;
    if8.valid_mask = 8'hFF;
    step();
    n_checks++;
    if (if8.victim_way !== 3'd4 || if8.victim_onehot !== 8'h10) begin
      n_fail++;
      $display("FAIL a8_way0: w=%0d oh=%h want 4/10",
               if8.victim_way, if8.victim_onehot);
    end
  endtask

  task automatic test_clear();
    u4(3'd5, 4'b0001);
    step();
    clear = 1'b1;
    u4(3'd5, 4'b0001);
    q4(3'd5, 4'hF);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd0) begin
      n_fail++;
      $display("FAIL clear_same: w=%0d want 0", if4.victim_way);
    end
    q4(3'd5, 4'hF);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd0) begin
      n_fail++;
      $display("FAIL clear_next: w=%0d want 0", if4.victim_way);
    end
    clear = 1'b1;
    q4(3'd0, 4'b1101);
    step();
    n_checks++;
    if (if4.victim_way !== 2'd1) begin
      n_fail++;
      $display("FAIL clear_inv: w=%0d want 1", if4.victim_way);
    end
  endtask

  task automatic test_async_reset();
    u4(3'd1, 4'b0001);
    step();
    q4(3'd3, 4'b0111);
    @(posedge clk);
    #1;
    idle();
    resetn = 1'b0;
    #2;
    n_checks++;
    if (if4.victim_valid !== 1'b0 || if4.victim_way !== 2'd0 ||
        if4.victim_onehot !== 4'd0) begin
      n_fail++;
      $display("FAIL async_rst: v=%b w=%0d oh=%b want 0/0/0",
               if4.victim_valid, if4.victim_way, if4.victim_onehot);
    end
    resetn = 1'b1;
    step();
    n_checks++;
    if (if4.victim_valid !== 1'b0 || if4.victim_onehot !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_no_out: v=%b oh=%b want 0/0",
               if4.victim_valid, if4.victim_onehot);
    end
    q4(3'd1, 4'hF);
    step();
    n_checks++;
    if (if4.victim_valid !== 1'b1 || if4.victim_way !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_state: v=%b w=%0d want 1/0",
               if4.victim_valid, if4.victim_way);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    resetn = 1'b1;
    idle();
    #3;
    test_reset();
    test_update_seq();
    test_forward();
    test_invalid_pref();
    test_assoc8();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
